// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the transfer-width codes, FSM states and requester indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        DW_0  = 2'b00,
        DW_8  = 2'b01,
        DW_16 = 2'b10,
        DW_32 = 2'b11
    } data_width_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_WAIT_RD = 2'b10,
        ST_HOLD    = 2'b11
    } arb_state_e;

    localparam int REQ_CART = 0;
    localparam int REQ_USB  = 1;

    localparam int STARVE_W  = 8;
    localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection for the memory arbiter: cart has priority unless the USB
// requester has been passed over USB_STARVE_LIMIT times in a row.
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int USB_STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic                idle,
    input  logic                grant_stb,
    output logic [1:0]          winner,
    output logic [STARVE_W-1:0] starve_cnt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(USB_STARVE_LIMIT);

    logic usb_starved;

    assign usb_starved = req_valid[REQ_USB] && (starve_cnt == LIMIT);

    always_comb begin
        winner = '0;
        if (req_valid[REQ_CART] && !usb_starved) begin
            winner[REQ_CART] = 1'b1;
        end else if (req_valid[REQ_USB]) begin
            winner[REQ_USB] = 1'b1;
        end
    end

    // Counts cart grants that bypassed a waiting USB request; a quiet USB
    // side in IDLE forgets any earlier backlog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_stb && winner[REQ_USB]) begin
            starve_cnt <= '0;
        end else if (grant_stb && winner[REQ_CART] && req_valid[REQ_USB]) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else if (idle && !req_valid[REQ_USB]) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (cart real-time, USB bulk) with latched
// command fields. Define MEM_ARB_TIMEOUT_EN to enable the completion watchdog.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W           = 26,
    parameter int DATA_W           = 32,
    parameter int USB_STARVE_LIMIT = 8,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_wr,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][1:0]        req_width,
    input  logic [1:0][DATA_W-1:0] req_wr_data,
    output logic [1:0]             grant,
    output logic [1:0]             req_done,
    output logic [1:0]             req_err,
    output logic [DATA_W-1:0]      req_rd_data,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [1:0]             mem_data_width,
    output logic [DATA_W-1:0]      mem_wr_data,
    input  logic                   mem_rd_ready,
    input  logic                   mem_wr_ready,
    input  logic                   mem_rd_valid,
    input  logic [DATA_W-1:0]      mem_rd_data,
    output logic [1:0]             dbg_state,
    output logic [STARVE_W-1:0]    dbg_starve_cnt
);

    // Requester handshake: req_valid rises with stable fields and stays high
    // until req_done; dropping it early aborts the transaction.

    arb_state_e state;
    logic       owner;
    logic       wr_q;
    logic       discard;
    logic [1:0] winner;
    logic       win_idx;
    logic       owner_valid;
    logic       idle;
    logic       grant_stb;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] tmo_cnt;
`endif

    assign idle        = (state == ST_IDLE);
    assign grant_stb   = idle && (|req_valid);
    assign win_idx     = winner[REQ_USB];
    assign owner_valid = req_valid[owner];
    assign dbg_state   = state;

    mem_arb_priority #(
        .USB_STARVE_LIMIT (USB_STARVE_LIMIT)
    ) u_priority (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .idle       (idle),
        .grant_stb  (grant_stb),
        .winner     (winner),
        .starve_cnt (dbg_starve_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            grant          <= '0;
            req_done       <= '0;
            req_err        <= '0;
            req_rd_data    <= '0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_addr       <= '0;
            mem_data_width <= DW_0;
            mem_wr_data    <= '0;
            owner          <= 1'b0;
            wr_q           <= 1'b0;
            discard        <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_stb) begin
                        grant          <= winner;
                        owner          <= win_idx;
                        wr_q           <= req_wr[win_idx];
                        mem_addr       <= req_addr[win_idx];
                        mem_data_width <= req_width[win_idx];
                        mem_wr_data    <= req_wr_data[win_idx];
                        discard        <= 1'b0;
                        state          <= ST_ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (!owner_valid) begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end else if (!wr_q && mem_rd_ready) begin
                        mem_rd <= 1'b1;
                        state  <= ST_WAIT_RD;
`ifdef MEM_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end else if (wr_q && mem_wr_ready) begin
                        mem_wr   <= 1'b1;
                        req_done <= grant;
                        state    <= ST_HOLD;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        req_done <= grant;
                        req_err  <= grant;
                        if (!wr_q) begin
                            req_rd_data <= '1;
                        end
                        state <= ST_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_WAIT_RD: begin
                    // A read already on the bus must finish even if its owner left.
                    if (!owner_valid) begin
                        discard <= 1'b1;
                    end
                    if (mem_rd_valid) begin
                        if (discard || !owner_valid) begin
                            grant <= '0;
                            state <= ST_IDLE;
                        end else begin
                            req_rd_data <= mem_rd_data;
                            req_done    <= grant;
                            state       <= ST_HOLD;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        if (discard || !owner_valid) begin
                            grant <= '0;
                            state <= ST_IDLE;
                        end else begin
                            req_done    <= grant;
                            req_err     <= grant;
                            req_rd_data <= '1;
                            state       <= ST_HOLD;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (!owner_valid) begin
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Registered two-requester arbiter that shares the single memory port between the cartridge bus engine (requester 0, real-time) and the USB FIFO engine (requester 1, bulk). It replaces fixed-priority muxing with cart-priority arbitration, a USB starvation guard, latched transaction fields and an optional completion watchdog. It sits between the cart/USB engines and the memory controller, directly below the address-translation buffer.

## Interface
- ADDR_W, 26, memory byte-address width
- DATA_W, 32, memory data width
- USB_STARVE_LIMIT, 8, consecutive cart grants allowed while USB waits (1..255)
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (2..65535)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  [1:0]  level request; held until req_done, then dropped
- req_wr  in  [1:0]  1 = write, 0 = read
- req_addr  in  [1:0][ADDR_W-1:0]  request address
- req_width  in  [1:0][1:0]  0/8/16/32-bit code (00/01/10/11)
- req_wr_data  in  [1:0][DATA_W-1:0]  write data
- grant  out  [1:0]  one-hot current owner, 0 when idle
- req_done  out  [1:0]  one-cycle completion pulse to owner
- req_err  out  [1:0]  one-cycle pulse with req_done on timeout
- req_rd_data  out  DATA_W  read data, valid while req_done of a read is high, held until next capture
- mem_rd, mem_wr  out  1  one-cycle command pulses
- mem_addr, mem_data_width, mem_wr_data  out  ADDR_W/2/DATA_W  latched at grant, held until next grant
- mem_rd_ready, mem_wr_ready, mem_rd_valid  in  1  memory handshake
- mem_rd_data  in  DATA_W  memory read data

## Operation
- Reset: all outputs 0, state IDLE, starvation counter 0.
- States: IDLE, ISSUE, WAIT_RD, HOLD.
- IDLE: if any req_valid, pick winner, set grant, latch winner's addr/width/wr_data/wr into mem_* registers -> ISSUE.
- Winner rule: cart wins if requesting unless USB is requesting and starve_cnt == USB_STARVE_LIMIT; otherwise USB if requesting.
- starve_cnt: +1 on each cart grant while req_valid[1] is high, saturating at limit; cleared on USB grant or when req_valid[1] is low in IDLE.
- ISSUE, read: on mem_rd_ready, pulse mem_rd -> WAIT_RD. Write: on mem_wr_ready, pulse mem_wr, pulse req_done -> HOLD.
- WAIT_RD: on mem_rd_valid, capture mem_rd_data into req_rd_data, pulse req_done -> HOLD.
- HOLD: wait until owner's req_valid is low, then clear grant -> IDLE. No new grant is made in the same cycle.
- Owner drops req_valid in ISSUE before the command issues: abort to IDLE, no memory access, no req_done.
- Owner drops req_valid in WAIT_RD: complete the memory read, discard the data, suppress req_done, return to IDLE.
- Requests arriving outside IDLE wait; the non-owner's req_valid is ignored until IDLE.

## Timing
- Read, best case (ready high, mem_rd_valid one cycle after mem_rd): req_valid sampled at edge 0, grant at 1, mem_rd at 2, req_done at 4.
- Write, best case: grant at 1; mem_wr and req_done at 2.
- Minimum turnaround HOLD->IDLE->next grant is 2 cycles after req_valid falls.
- Simultaneous requests in IDLE resolve by the winner rule in one cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: a 16-bit counter runs in ISSUE and WAIT_RD and clears on each state entry.
  - If it reaches TIMEOUT_CYCLES, pulse req_done and req_err, set req_rd_data to all-ones for a read, and go to HOLD.
  - A mem_rd_valid arriving later is ignored.
- MEM_ARB_TIMEOUT_EN undefined: no counter; the arbiter waits indefinitely and req_err is tied to 0.

## Structure
- Shared package mem_arb_pkg holds:
  - data-width enum (DW_0/8/16/32)
  - state enum
  - requester index constants REQ_CART=0, REQ_USB=1
- Sub-module mem_arb_priority holds the winner selection and starvation counter. Its inputs are req_valid and a grant strobe; its outputs are a one-hot winner.

## Test plan
- Cart read of addr 0x0000100, mem returns 0x12345678 -> mem_rd at edge 2, req_done[0] and req_rd_data=0x12345678 at edge 4.
- Cart and USB request in the same cycle -> grant=01. After cart releases, grant=10.
- Cart requests continuously, USB waits, USB_STARVE_LIMIT=8 -> 8 cart grants, then 1 USB grant, counter returns to 0.
- Cart drops req_valid during ISSUE with mem_rd_ready low -> no mem_rd pulse, no req_done, state returns to IDLE.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, USB read never gets mem_rd_valid -> req_done[1] and req_err[1] 16 cycles after WAIT_RD entry, req_rd_data=0xFFFFFFFF.
- rst_n pulled low during WAIT_RD -> all outputs 0 immediately; after release, state is IDLE and the next cart request is served normally.
